seg_digit_scheduler: RTL

Time-multiplexes one shared hex-to-seven-segment decoder across NUM_DIGITS common-cathode/anode digits. Steps through the digits one slot at a time. Each slot has a blanking (dead-time) phase followed by a drive phase, which prevents ghosting. For each slot it presents that digit's 4-bit value to the decoder and asserts exactly one digit enable. It sits between the switch/value sources and the existing shared decoder and digit-enable transistor pins.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_slot_timer.sv | 37 +++
 rtl/seg_digit_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment digit scheduler.
// Optional brightness control is enabled with the SEG_DIM_EN macro.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int MAX_DIGITS = 8;
    localparam int IDX_MAX_W  = 3;

    // Width of a counter or index that must hold values 0..n-1, at least one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter for the digit scheduler: counts through one slot and flags
// the last dead-time cycle and the last cycle of the slot.
module seg_slot_timer #(
    parameter int SLOT_CYCLES = 102417,
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_dead_done,
    output logic             o_slot_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_slot_done;

    assign w_slot_done = (r_cnt == CNT_W'(SLOT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_run || w_slot_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_dead_done = (r_cnt == CNT_W'(DEAD_CYCLES - 1));
    assign o_slot_done = w_slot_done;

endmodule

// File: rtl/seg_digit_scheduler.sv
// Time-multiplexes one shared hex decoder across NUM_DIGITS digits with a
// blanking phase before each drive phase. SEG_DIM_EN adds bright_i on-time control.
module seg_digit_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int SLOT_CYCLES = 102417,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    en,
    input  logic [4*NUM_DIGITS-1:0]                 digits_i,
`ifdef SEG_DIM_EN
    input  logic [3:0]                              bright_i,
`endif
    output logic [3:0]                              hex_o,
    output logic [NUM_DIGITS-1:0]                   digit_en_o,
    output logic [cnt_width(NUM_DIGITS)-1:0]        idx_o,
    output logic                                    frame_o
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int CNT_W = cnt_width(SLOT_CYCLES);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_dead_done;
    logic                  w_slot_done;
    logic                  w_run;
    logic                  w_adv;
    logic                  w_latch;
    logic                  w_lit_next;
    logic                  w_last_idx;
    logic [IDX_W-1:0]      w_next_idx;
    logic [3:0]            w_sel;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            r_value;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_frame;

    assign w_run = en && (r_state != IDLE);

    seg_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_run       (w_run),
        .o_cnt       (w_cnt),
        .o_dead_done (w_dead_done),
        .o_slot_done (w_slot_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_adv        = 1'b0;
        if (!en) begin
            w_next_state = IDLE;
        end else begin
            unique case (r_state)
                IDLE:  w_next_state = BLANK;
                BLANK: if (w_dead_done) w_next_state = DRIVE;
                DRIVE: if (w_slot_done) begin
                    w_next_state = BLANK;
                    w_adv        = 1'b1;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    assign w_latch    = en && (r_state == BLANK) && (w_cnt == '0);
    assign w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_next_idx = w_last_idx ? '0 : r_idx + IDX_W'(1);
    assign w_sel      = digits_i[{r_idx, 2'b00} +: 4];

`ifdef SEG_DIM_EN
    localparam int ON_W = CNT_W + 1;

    logic [31:0]     w_on_cycles;
    logic [ON_W-1:0] w_fresh_end;
    logic [ON_W-1:0] w_on_end;
    logic [ON_W-1:0] r_on_end;

    // Enables stay lit while the slot counter is below DEAD_CYCLES + on-cycles.
    assign w_on_cycles = (32'(SLOT_CYCLES - DEAD_CYCLES) * (32'(bright_i) + 32'd1)) >> 4;
    assign w_fresh_end = ON_W'(DEAD_CYCLES) + ON_W'(w_on_cycles);
    assign w_on_end    = w_latch ? w_fresh_end : r_on_end;
    assign w_lit_next  = (r_state == DRIVE) ? ((ON_W'(w_cnt) + ON_W'(1)) < w_on_end)
                                            : (ON_W'(DEAD_CYCLES) < w_on_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_on_end <= '0;
        end else if (w_latch) begin
            r_on_end <= w_fresh_end;
        end
    end
`else
    assign w_lit_next = 1'b1;
`endif

    // Enables are computed from the next state so they are registered yet
    // line up exactly with the DRIVE state; async reset drops them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_value    <= '0;
            r_digit_en <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_frame <= w_adv && w_last_idx;
            if (w_adv) begin
                r_idx <= w_next_idx;
            end
            if (w_latch) begin
                r_value <= w_sel;
            end
            r_digit_en <= ((w_next_state == DRIVE) && w_lit_next)
                        ? NUM_DIGITS'(onehot(IDX_MAX_W'(r_idx))) : '0;
        end
    end

    assign hex_o      = r_value;
    assign digit_en_o = r_digit_en;
    assign idx_o      = r_idx;
    assign frame_o    = r_frame;

endmodule
